error_status_bank: RTL and testbench
====================================

Name: error_status_bank

Overview:
- Multi-channel successor to the single sticky error latch.
- Captures N_CH independent error inputs into sticky flags, each with a saturating occurrence counter.
- Records which channel(s) failed first and raises a maskable interrupt.
- Sits between the fitter datapath error sources and the slow-control/readout register map.

Parameters:
- N_CH, 8: number of error channels, 1..32.
- CNT_W, 8: width of each per-channel saturating occurrence counter, 2..16.
- SEL_W, $clog2(N_CH) with minimum 1: width of the counter readback select.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; all state is cleared while low.
- error  in  N_CH  per-channel error level, synchronous to clock.
- clear  in  N_CH  per-channel clear pulse; clears sticky flag and counter.
- clear_all  in  1  clears every channel plus the first-error capture.
- mask  in  N_CH  1 = channel excluded from irq; does not block latching or counting.
- sticky  out  N_CH  latched error flags.
- first_err  out  N_CH  channel(s) whose event set first_valid.
- first_valid  out  1  first_err holds a valid capture.
- count_sel  in  SEL_W  selects the counter to read back.
- count_out  out  CNT_W  registered counter value of the selected channel.
- irq  out  1  |(sticky & ~mask).

Behaviour:
- Reset (reset=0, asynchronous): sticky=0, all counters=0, first_err=0, first_valid=0, count_out=0, irq=0. Internal edge registers reset to 0.
- Event per channel: ev[i] = error[i] (level mode, default). Edge mode is described under Optional Feature.
- Sticky per channel, next state:
  - clear_all or clear[i], with ev[i]=0: 0.
  - ev[i]=1: 1. An event wins over a clear in the same cycle.
  - otherwise: hold.
- Sticky latency: ev at rising edge k gives sticky set, visible after edge k.
- Counter per channel, unsigned, saturating at 2^CNT_W-1. Never wraps.
  - Clear (clear[i] or clear_all) with ev[i]=1: 1.
  - Clear with ev[i]=0: 0.
  - ev[i]=1, no clear: increment if below max, else hold.
  - Level mode counts every asserted cycle.
- First-error capture:
  - If first_valid=0 and |ev: first_err<=ev and first_valid<=1. Simultaneous events give a multi-hot first_err.
  - While first_valid=1, first_err is frozen. Per-channel clear does not affect it.
  - clear_all: first_valid<=0, first_err<=0. If |ev in the same cycle, the new capture wins: first_valid=1, first_err=ev.
- count_out: registered. count_out<=counter[count_sel], 1-cycle latency. count_sel>=N_CH gives 0.
- irq: combinational OR of registered sticky & ~mask. Glitch-free relative to clock. Changing mask affects irq immediately, with no state change.
- Reset asserted mid-operation: everything clears at once, regardless of clock. Deassertion is expected synchronised upstream.

Optional Feature:
- Macro: ERROR_STATUS_EDGE_DETECT_EN.
- Defined: per-channel error_d register (reset 0); ev[i] = error[i] & ~error_d[i]. A long error pulse counts once; a held-high input re-counts only after it drops and rises again.
- Undefined: ev = error (level mode), and no error_d registers are instantiated.

Decomposition:
- Shared include/package error_status_defs holds:
  - default N_CH / CNT_W constants;
  - count_out value for an out-of-range select (0);
  - the saturation-max expression.
- One natural sub-module: error_status_chan. It holds one channel's sticky bit, saturating counter and optional edge register. It is instantiated N_CH times in a generate loop. The top module keeps first-error capture, readback mux and irq.

Test Plan:
- Reset and first capture: reset low then released; error=8'h04 for 1 cycle:
  - sticky=8'h04, first_err=8'h04, first_valid=1, irq=1;
  - count_sel=2 gives count_out=1 one cycle later.
- Saturation: CNT_W=2, level mode, error[0] high 10 cycles -> counter[0]=3, held; sticky[0]=1.
- Simultaneous events and masking: error=8'h81 in one cycle, mask=8'h81:
  - first_err=8'h81;
  - irq=0; clearing mask bit 7 gives irq=1 with no clock edge needed.
- Clear vs event collision:
  - clear[3]=1 and error[3]=1 in the same cycle -> sticky[3]=1, counter[3]=1;
  - clear_all with error=0 -> all zero, first_valid=0.
- Async reset mid-run: counters at 5, reset pulled low between edges -> all outputs 0 before the next edge.
- Edge mode (macro defined): error[1] high 6 cycles, low 2, high 3 -> counter[1]=2; level build gives 9.

Source files
------------

// File: rtl/error_status_defs.sv
// Shared constants for the error status bank.
// Default channel/counter sizes, out-of-range readback value, saturation max.
package error_status_defs;

  localparam int N_CH_DEF  = 8;
  localparam int CNT_W_DEF = 8;
  localparam int OOR_COUNT = 0;

  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/error_status_chan.sv
// One error channel: sticky flag, saturating counter, optional edge register.
// ERROR_STATUS_EDGE_DETECT_EN selects rising-edge events instead of level.
module error_status_chan
  import error_status_defs::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             error,
  input  logic             clear,
  output logic             ev,
  output logic             sticky,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(sat_max(CNT_W));

`ifdef ERROR_STATUS_EDGE_DETECT_EN
  logic error_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) error_d <= 1'b0;
    else        error_d <= error;
  end

  assign ev = error & ~error_d;
`else
  assign ev = error;
`endif

  // An event in the same cycle as a clear wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     sticky <= 1'b0;
    else if (ev)    sticky <= 1'b1;
    else if (clear) sticky <= 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clear)
      count <= ev ? CNT_W'(1) : '0;
    else if (ev && count != CNT_MAX)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/error_status_bank.sv
// Multi-channel sticky error bank with first-error capture and maskable irq.
// ERROR_STATUS_EDGE_DETECT_EN switches channels to edge-detected events.
module error_status_bank
  import error_status_defs::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_CH-1:0]  error,
  input  logic [N_CH-1:0]  clear,
  input  logic             clear_all,
  input  logic [N_CH-1:0]  mask,
  output logic [N_CH-1:0]  sticky,
  output logic [N_CH-1:0]  first_err,
  output logic             first_valid,
  input  logic [SEL_W-1:0] count_sel,
  output logic [CNT_W-1:0] count_out,
  output logic             irq
);

  logic [N_CH-1:0]  ev;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [CNT_W-1:0] sel_cnt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    error_status_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .error  (error[i]),
      .clear  (clear[i] | clear_all),
      .ev     (ev[i]),
      .sticky (sticky[i]),
      .count  (cnt[i])
    );
  end

  // A capture in the clear_all cycle overrides the clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_err   <= '0;
      first_valid <= 1'b0;
    end else if (|ev && (!first_valid || clear_all)) begin
      first_err   <= ev;
      first_valid <= 1'b1;
    end else if (clear_all) begin
      first_err   <= '0;
      first_valid <= 1'b0;
    end
  end

  always_comb begin
    sel_cnt = CNT_W'(OOR_COUNT);
    for (int i = 0; i < N_CH; i++) begin
      if (count_sel == SEL_W'(i)) sel_cnt = cnt[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_out <= '0;
    else        count_out <= sel_cnt;
  end

  assign irq = |(sticky & ~mask);

endmodule

// File: tb/tb_error_status_bank.sv
// Randomized and directed bench for error_status_bank.
// Two instances share stimulus: 8-bit and 2-bit counters.
module tb_error_status_bank;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] error = '0;
  logic [7:0] clear = '0;
  logic       clear_all = 1'b0;
  logic [7:0] mask = '0;
  logic [2:0] count_sel = '0;

  logic [7:0] sticky, first_err;
  logic       first_valid, irq;
  logic [7:0] count_out;

  logic [7:0] sticky2, first_err2;
  logic       first_valid2, irq2;
  logic [1:0] count_out2;

  int passed = 0;
  int total = 0;

  bit [7:0] m_sticky, m_first, m_prev;
  bit       m_fv;
  int       m_cnt [8];
  int       m_co, m_co2;

  always #5 clock = ~clock;

  error_status_bank #(.N_CH(8), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .error(error), .clear(clear),
    .clear_all(clear_all), .mask(mask), .sticky(sticky),
    .first_err(first_err), .first_valid(first_valid),
    .count_sel(count_sel), .count_out(count_out), .irq(irq)
  );

  error_status_bank #(.N_CH(8), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .error(error), .clear(clear),
    .clear_all(clear_all), .mask(mask), .sticky(sticky2),
    .first_err(first_err2), .first_valid(first_valid2),
    .count_sel(count_sel), .count_out(count_out2), .irq(irq2)
  );

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_sticky = '0; m_first = '0; m_prev = '0; m_fv = 0;
    m_co = 0; m_co2 = 0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
  endtask

  // Advance one clock and apply the spec rules to the model.
  task automatic cycle();
    bit [7:0] ev;
    bit clr;
    @(posedge clock);
    m_co  = sat(m_cnt[count_sel], 255);
    m_co2 = sat(m_cnt[count_sel], 3);
`ifdef ERROR_STATUS_EDGE_DETECT_EN
    ev = error & ~m_prev;
`else
    ev = error;
`endif
    m_prev = error;
    for (int i = 0; i < 8; i++) begin
      clr = clear_all | clear[i];
      if (clr) m_cnt[i] = ev[i] ? 1 : 0;
      else if (ev[i]) m_cnt[i] = m_cnt[i] + 1;
      if (ev[i]) m_sticky[i] = 1'b1;
      else if (clr) m_sticky[i] = 1'b0;
    end
    if (ev != 0 && (!m_fv || clear_all)) begin
      m_first = ev; m_fv = 1'b1;
    end else if (clear_all) begin
      m_first = '0; m_fv = 1'b0;
    end
    #1;
  endtask

  task automatic quiet_clear_all();
    error = '0; clear = '0; clear_all = 1'b1;
    cycle();
    clear_all = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (sticky !== 8'h00 || first_valid !== 1'b0 || irq !== 1'b0)
      $display("FAIL reset_flags sticky=%h fv=%b irq=%b want 00/0/0",
               sticky, first_valid, irq);
    else passed++;
    total++;
    if (first_err !== 8'h00 || count_out !== 8'h00)
      $display("FAIL reset_regs first_err=%h count_out=%h want 00/00",
               first_err, count_out);
    else passed++;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_first_capture();
    error = 8'h04;
    cycle();
    error = 8'h00;
    total++;
    if (sticky !== 8'h04 || first_err !== 8'h04 || first_valid !== 1'b1)
      $display("FAIL first_capture sticky=%h fe=%h fv=%b want 04/04/1",
               sticky, first_err, first_valid);
    else passed++;
    total++;
    if (irq !== 1'b1) $display("FAIL first_irq irq=%b want 1", irq);
    else passed++;
    count_sel = 3'd2;
    cycle();
    total++;
    if (count_out !== 8'd1)
      $display("FAIL first_count count_out=%0d want 1", count_out);
    else passed++;
  endtask

  task automatic test_saturation();
    quiet_clear_all();
    count_sel = 3'd0;
    error = 8'h01;
    repeat (10) cycle();
    error = 8'h00;
    cycle();
    total++;
`ifdef ERROR_STATUS_EDGE_DETECT_EN
    if (count_out2 !== 2'd1)
      $display("FAIL saturation count=%0d want 1", count_out2);
`else
    if (count_out2 !== 2'd3)
      $display("FAIL saturation count=%0d want 3", count_out2);
`endif
    else passed++;
    total++;
    if (sticky2[0] !== 1'b1 || count_out !== 8'(m_co))
      $display("FAIL saturation_wide sticky=%b cnt=%0d want 1/%0d",
               sticky2[0], count_out, m_co);
    else passed++;
  endtask

  task automatic test_simul_mask();
    quiet_clear_all();
    error = 8'h81; mask = 8'h81;
    cycle();
    error = 8'h00;
    total++;
    if (first_err !== 8'h81 || first_valid !== 1'b1)
      $display("FAIL simul_first fe=%h fv=%b want 81/1",
               first_err, first_valid);
    else passed++;
    total++;
    if (irq !== 1'b0) $display("FAIL masked_irq irq=%b want 0", irq);
    else passed++;
    #2 mask = 8'h01;
    #1;
    total++;
    if (irq !== 1'b1) $display("FAIL unmask_irq irq=%b want 1", irq);
    else passed++;
    mask = 8'h00;
  endtask

  task automatic test_clear_collision();
    quiet_clear_all();
    clear = 8'h08; error = 8'h08; count_sel = 3'd3;
    cycle();
    clear = 8'h00; error = 8'h00;
    cycle();
    total++;
    if (sticky[3] !== 1'b1 || count_out !== 8'd1)
      $display("FAIL clear_collision sticky3=%b cnt=%0d want 1/1",
               sticky[3], count_out);
    else passed++;
    quiet_clear_all();
    total++;
    if (sticky !== 8'h00 || first_valid !== 1'b0 || first_err !== 8'h00)
      $display("FAIL clear_all sticky=%h fv=%b fe=%h want 00/0/00",
               sticky, first_valid, first_err);
    else passed++;
  endtask

  task automatic test_async_reset();
    quiet_clear_all();
    count_sel = 3'd5;
    for (int k = 0; k < 5; k++) begin
      error = 8'hFF;
      cycle();
      error = 8'h00;
`ifdef ERROR_STATUS_EDGE_DETECT_EN
      cycle();
`endif
    end
    cycle();
    total++;
    if (count_out !== 8'd5)
      $display("FAIL pre_reset_count count_out=%0d want 5", count_out);
    else passed++;
    #2 reset = 1'b0;
    #1;
    total++;
    if (sticky !== 8'h00 || first_valid !== 1'b0 || irq !== 1'b0 ||
        count_out !== 8'h00 || first_err !== 8'h00)
      $display("FAIL async_reset st=%h fv=%b irq=%b cnt=%h fe=%h want 0",
               sticky, first_valid, irq, count_out, first_err);
    else passed++;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_edge_mode();
    quiet_clear_all();
    count_sel = 3'd1;
    error = 8'h02; repeat (6) cycle();
    error = 8'h00; repeat (2) cycle();
    error = 8'h02; repeat (3) cycle();
    error = 8'h00;
    cycle();
    total++;
`ifdef ERROR_STATUS_EDGE_DETECT_EN
    if (count_out !== 8'd2)
      $display("FAIL edge_count count_out=%0d want 2", count_out);
`else
    if (count_out !== 8'd9)
      $display("FAIL level_count count_out=%0d want 9", count_out);
`endif
    else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 8; i++) begin
        error[i] = ($urandom_range(0, 3) == 0);
        clear[i] = ($urandom_range(0, 15) == 0);
      end
      clear_all = ($urandom_range(0, 40) == 0);
      mask = 8'($urandom);
      count_sel = 3'($urandom);
      if (n % 300 < 20) error = 8'hFF;
      cycle();
      total++;
      if (sticky !== m_sticky || sticky2 !== m_sticky)
        $display("FAIL rnd_sticky n=%0d got=%h/%h want=%h",
                 n, sticky, sticky2, m_sticky);
      else passed++;
      total++;
      if (first_err !== m_first || first_valid !== m_fv)
        $display("FAIL rnd_first n=%0d got=%h/%b want=%h/%b",
                 n, first_err, first_valid, m_first, m_fv);
      else passed++;
      total++;
      if (count_out !== 8'(m_co) || count_out2 !== 2'(m_co2))
        $display("FAIL rnd_count n=%0d got=%0d/%0d want=%0d/%0d",
                 n, count_out, count_out2, m_co, m_co2);
      else passed++;
      total++;
      if (irq !== |(m_sticky & ~mask))
        $display("FAIL rnd_irq n=%0d got=%b want=%b",
                 n, irq, |(m_sticky & ~mask));
      else passed++;
    end
    error = '0; clear = '0; clear_all = 1'b0; mask = '0;
  endtask

  initial begin
    test_reset();
    test_first_capture();
    test_saturation();
    test_simul_mask();
    test_clear_collision();
    test_async_reset();
    test_edge_mode();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
